// File: rtl/noop_exc_pkg.sv
// Shared types and constants for the exception/eret recovery controller.
package noop_exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_GUARD    = 2'd3
    } exc_state_e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
    localparam int          EXC_CNT_W          = 16;

    // A commit only starts recovery when CP0 reports an exception or an eret.
    function automatic logic is_trigger(input logic valid, input logic exc, input logic eret);
        return valid & (exc | eret);
    endfunction

endpackage

// File: rtl/exc_redirect_ctrl.sv
// Pipeline recovery sequencer: after a CP0 exception/eret commit it flushes,
// redirects fetch over valid/ready, then guards one cycle before reopening.
module exc_redirect_ctrl
    import noop_exc_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = EXC_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    output logic                  commit_ready,
    input  logic                  has_exception,
    input  logic                  eret,
    input  logic [DATA_WIDTH-1:0] epc,
    output logic                  flush,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  int_enable,
    output logic                  busy,
    output logic [EXC_CNT_W-1:0]  exc_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    exc_state_e            state_q, state_d;
    logic [3:0]            fcnt_q, fcnt_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // State, flush counter, redirect target and exception counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fcnt_q  <= 4'd0;
            pc_q    <= {DATA_WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the target is latched at acceptance so it stays stable until the next trigger.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (is_trigger(commit_valid, has_exception, eret)) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = 4'(FLUSH_CYCLES);
                    if (has_exception) begin
                        pc_d = DATA_WIDTH'(EXC_VECTOR);
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else begin
                        pc_d = epc;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q <= 4'd1) begin
                    state_d = ST_REDIRECT;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d  = fcnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_GUARD;
                end else begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_GUARD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs come from state/registers only, never straight from the handshake inputs.
    assign commit_ready   = (state_q == ST_IDLE);
    assign int_enable     = (state_q == ST_IDLE);
    assign flush          = (state_q == ST_FLUSH);
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign busy           = (state_q != ST_IDLE);
    assign redirect_pc    = pc_q;
    assign exc_count      = EXC_CNT_W'(cnt_q);

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl with a cycle-timeline reference model.
module tb_exc_redirect_ctrl;

    localparam int          FC  = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, has_exception, eret, redirect_ready;
    logic [31:0] epc;
    logic        commit_ready, flush, redirect_valid, int_enable, busy;
    logic [31:0] redirect_pc;
    logic [15:0] exc_count;
    logic        s_commit_ready, s_flush, s_redirect_valid, s_int_enable, s_busy;
    logic [31:0] s_redirect_pc;
    logic [15:0] s_exc_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    exc_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_ready(commit_ready),
        .has_exception(has_exception), .eret(eret), .epc(epc), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .int_enable(int_enable), .busy(busy),
        .exc_count(exc_count)
    );

    // Narrow counter copy, so saturation is reachable in a short run.
    exc_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_ready(s_commit_ready),
        .has_exception(has_exception), .eret(eret), .epc(epc), .flush(s_flush),
        .redirect_valid(s_redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(s_redirect_pc), .int_enable(s_int_enable), .busy(s_busy),
        .exc_count(s_exc_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a recovery sequence is a trigger cycle T plus a handshake cycle H.
    int          n      = 0;
    int          t_trig = -1;
    int          t_hs   = -1;
    logic [31:0] m_tgt  = 32'd0;
    int          m_cnt  = 0;

    // 0 idle, 1 flush, 2 redirect, 3 guard
    function automatic int phase(input int c);
        if (t_trig < 0 || c <= t_trig) return 0;
        if (c <= t_trig + FC) return 1;
        if (t_hs < 0 || c <= t_hs) return 2;
        if (c == t_hs + 1) return 3;
        return 0;
    endfunction

    initial begin
        int p;
        int p_prev;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (rst) begin
                t_trig = -1;
                t_hs   = -1;
                m_tgt  = 32'd0;
                m_cnt  = 0;
            end else begin
                p_prev = phase(n - 1);
                if (p_prev == 0 && commit_valid && (has_exception || eret)) begin
                    t_trig = n - 1;
                    t_hs   = -1;
                    m_tgt  = has_exception ? VEC : epc;
                    if (has_exception) m_cnt++;
                end else if (p_prev == 2 && redirect_ready) begin
                    t_hs = n - 1;
                end
            end
            p = rst ? 0 : phase(n);
            chk("m_commit_ready", 32'(commit_ready), 32'(p == 0));
            chk("m_int_enable", 32'(int_enable), 32'(p == 0));
            chk("m_flush", 32'(flush), 32'(p == 1));
            chk("m_redirect_valid", 32'(redirect_valid), 32'(p == 2));
            chk("m_busy", 32'(busy), 32'(p != 0));
            chk("m_exc_count", 32'(exc_count), 32'((m_cnt > 65535) ? 65535 : m_cnt));
            chk("m_exc_count_sat4", 32'(s_exc_count), 32'((m_cnt > 15) ? 15 : m_cnt));
            if (rst || p == 2) chk("m_redirect_pc", redirect_pc, m_tgt);
        end
    end

    task automatic nxt(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    // Exception with ready held high; checks the canonical T+1..T+5 timeline.
    task automatic run_exc_seq(input logic [15:0] exp_cnt);
        commit_valid = 1'b1; has_exception = 1'b1; eret = 1'b0; redirect_ready = 1'b1;
        nxt();
        commit_valid = 1'b0; has_exception = 1'b0;
        chk("exc_flush_t1", 32'(flush), 32'd1);
        chk("exc_inten_t1", 32'(int_enable), 32'd0);
        nxt();
        chk("exc_flush_t2", 32'(flush), 32'd1);
        nxt();
        chk("exc_rv_t3", 32'(redirect_valid), 32'd1);
        chk("exc_pc_t3", redirect_pc, 32'hBFC00380);
        chk("exc_flush_t3", 32'(flush), 32'd0);
        nxt();
        chk("exc_guard_inten", 32'(int_enable), 32'd0);
        chk("exc_guard_cready", 32'(commit_ready), 32'd0);
        nxt();
        chk("exc_idle_cready", 32'(commit_ready), 32'd1);
        chk("exc_count", 32'(exc_count), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1; commit_valid = 1'b0; has_exception = 1'b0; eret = 1'b0;
        redirect_ready = 1'b0; epc = 32'd0;
        nxt(2);
        chk("rst_cready", 32'(commit_ready), 32'd1);
        chk("rst_inten", 32'(int_enable), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(exc_count), 32'd0);
        rst = 1'b0;
        nxt(2);

        run_exc_seq(16'd1);

        // eret with IFU stalling for four redirect cycles
        commit_valid = 1'b1; eret = 1'b1; epc = 32'h80001234; redirect_ready = 1'b0;
        nxt();
        commit_valid = 1'b0; eret = 1'b0; epc = 32'h0;
        nxt(2);
        for (int i = 0; i < 4; i++) begin
            chk("eret_rv_stall", 32'(redirect_valid), 32'd1);
            chk("eret_pc_stall", redirect_pc, 32'h80001234);
            nxt();
        end
        redirect_ready = 1'b1;
        chk("eret_rv_ready", 32'(redirect_valid), 32'd1);
        nxt(2);
        chk("eret_idle", 32'(commit_ready), 32'd1);
        chk("eret_count", 32'(exc_count), 32'd1);

        // exception and eret together: exception wins
        commit_valid = 1'b1; has_exception = 1'b1; eret = 1'b1; epc = 32'h80000040;
        nxt();
        commit_valid = 1'b0; has_exception = 1'b0; eret = 1'b0;
        nxt(2);
        chk("both_pc", redirect_pc, 32'hBFC00380);
        nxt(2);
        chk("both_count", 32'(exc_count), 32'd2);

        // back-to-back: commit held through the whole first sequence
        commit_valid = 1'b1; eret = 1'b1; epc = 32'h80000100;
        nxt();
        chk("b2b_not_ready", 32'(commit_ready), 32'd0);
        nxt(4);
        chk("b2b_ready_again", 32'(commit_ready), 32'd1);
        nxt();
        commit_valid = 1'b0; eret = 1'b0;
        chk("b2b_second_flush", 32'(flush), 32'd1);
        nxt(4);
        chk("b2b_idle", 32'(busy), 32'd0);

        // asynchronous reset in the middle of REDIRECT
        commit_valid = 1'b1; eret = 1'b1; epc = 32'h80000200; redirect_ready = 1'b0;
        nxt();
        commit_valid = 1'b0; eret = 1'b0;
        nxt(2);
        chk("arst_pre_rv", 32'(redirect_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rv", 32'(redirect_valid), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pc", redirect_pc, 32'd0);
        chk("arst_count", 32'(exc_count), 32'd0);
        nxt();
        rst = 1'b0; redirect_ready = 1'b1;
        nxt();
        run_exc_seq(16'd1);

        // saturation of the narrow counter copy
        for (int i = 0; i < 17; i++) begin
            commit_valid = 1'b1; has_exception = 1'b1;
            nxt();
            commit_valid = 1'b0; has_exception = 1'b0;
            nxt(4);
        end
        chk("sat_small", 32'(s_exc_count), 32'd15);
        chk("sat_main", 32'(exc_count), 32'd18);
        commit_valid = 1'b1; has_exception = 1'b1;
        nxt();
        commit_valid = 1'b0; has_exception = 1'b0;
        nxt(4);
        chk("sat_small_hold", 32'(s_exc_count), 32'd15);
        chk("sat_main_next", 32'(exc_count), 32'd19);

        // plain commit is accepted and ignored
        commit_valid = 1'b1;
        nxt();
        commit_valid = 1'b0;
        chk("plain_ignored", 32'(busy), 32'd0);
        nxt(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
